p_ng_wr_adapter: RTL and testbench
==================================

Name: p_ng_wr_adapter

Overview:
- Upstream feeder for the ping-pong packet memory stage (p_ng).
- Accepts an AXI-Stream-style snooped packet stream and converts each accepted beat into a registered write (wr_en/addr/idata/byte_inc) into one packet-memory buffer.
- Clears the buffer's length counter at packet start and signals packet completion to the buffer-handoff logic.
- Truncates packets that exceed buffer capacity.

Parameters:
- ADDR_WIDTH, 10, packet-memory word address width; buffer holds 2^ADDR_WIDTH words.
- DATA_WIDTH, 64, stream and memory word width; must be a multiple of 8.
- INC_WIDTH, 8, width of byte_inc; must be at least clog2(DATA_WIDTH/8)+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- sn_TDATA  in  DATA_WIDTH  stream data; byte 0 in the MSBs
- sn_TKEEP  in  DATA_WIDTH/8  byte valid mask; contiguous from the MSB end
- sn_TLAST  in  1  last beat of packet
- sn_TVALID  in  1  beat valid
- sn_TREADY  out  1  adapter accepts beat
- buf_rdy  in  1  an empty packet buffer is available to write
- pm_clr  out  1  one-cycle pulse clearing the buffer's byte length
- wr_en  out  1  packet-memory write strobe
- addr  out  ADDR_WIDTH  packet-memory word address
- idata  out  DATA_WIDTH  packet-memory write data
- byte_inc  out  INC_WIDTH  valid bytes in this write
- done  out  1  packet complete in buffer; level, held until acknowledged
- trunc  out  1  packet was truncated; valid while done=1
- done_ack  in  1  handoff logic has taken the buffer

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE.
  - sn_TREADY, pm_clr, wr_en, done, trunc = 0.
  - addr, idata, byte_inc = 0.
  - Internal word pointer = 0 and full flag = 0.
- Reset mid-packet abandons the packet. After reset release, stream beats are ignored (TREADY=0) until the IDLE->WRITE entry.
- States:
  - IDLE -> CLEAR when buf_rdy=1.
  - CLEAR (one cycle): pm_clr=1, pointer cleared, full flag cleared -> WRITE.
  - WRITE: sn_TREADY=1.
    - A handshake (TVALID & TREADY) with TLAST=1 -> DONE on the next edge.
  - DONE: done=1, TREADY=0.
    - done_ack=1 -> IDLE.
    - If buf_rdy is also high in that cycle, IDLE still takes one cycle before CLEAR. No state skipping.
- Write path:
  - All outputs are registered; latency is 1 cycle from handshake to wr_en.
  - On a handshake with the full flag clear and popcount(TKEEP)!=0:
    - wr_en=1, addr=pointer, idata=TDATA, byte_inc=popcount(TKEEP), zero-extended to INC_WIDTH.
    - pointer increments.
  - A beat with TKEEP=0 is consumed with no write and no pointer change.
  - wr_en is 0 on any cycle without a qualifying handshake. addr, idata and byte_inc hold their last values.
- Boundary:
  - When the write at pointer 2^ADDR_WIDTH-1 is issued and TLAST=0, the full flag is set. Pointer wraps to 0 but is unused.
  - While full, beats are accepted (TREADY=1) and discarded until TLAST.
  - trunc is set at the TLAST handshake if the full flag was set. It is cleared in CLEAR.
  - A packet whose TLAST lands exactly on word 2^ADDR_WIDTH-1 is not truncated.
- done rises in the cycle after the final wr_en, so the final write is committed before handoff.
- done_ack outside DONE is ignored.

Optional Feature:
- Macro: P_NG_WR_STATS_EN.
- When defined:
  - Adds outputs pkt_cnt [31:0], incremented on every entry to DONE.
  - Adds outputs trunc_cnt [31:0], incremented on entry to DONE with trunc=1.
  - Both counters reset to 0 on rst_n, saturate at all-ones, and are never cleared otherwise.
- When undefined: the ports and the logic are absent. All other behaviour is identical.

Test Plan:
- Reset/idle: rst_n=0 then release with buf_rdy=0 and TVALID=1 -> TREADY=0 and no wr_en for 10 cycles; all outputs 0.
- Basic packet: buf_rdy=1; stream 3 beats with TKEEP=FF, FF, F0 and TLAST on beat 3.
  - One pm_clr pulse, then wr_en at addr 0, 1, 2 with byte_inc 8, 8, 4.
  - done=1 one cycle after the last write; trunc=0.
  - done_ack -> IDLE.
- Backpressure/gaps: TVALID toggling 1,0,1,0 over 2 beats -> exactly 2 writes at addr 0 and 1, with no duplicate writes.
- Exact fit vs truncation (ADDR_WIDTH=2):
  - 4-beat packet -> 4 writes, trunc=0.
  - 6-beat packet -> 4 writes, beats 5-6 accepted with no write, trunc=1.
- Zero-keep beat: TKEEP=00 mid-packet -> no write and addr unchanged; the next beat is written at the next address.
- Async reset mid-packet: rst_n low after 2 writes -> outputs 0 immediately.
  - After release with buf_rdy=1: a new pm_clr, and the next packet is written starting at addr 0.
  - With P_NG_WR_STATS_EN, pkt_cnt=0.

Source files
------------

// File: rtl/p_ng_wr_adapter_if.sv
// Snooped packet stream plus packet-memory write bus for the p_ng write adapter.
// slave = adapter view, master = environment (stream source, memory, handoff logic).
interface p_ng_wr_adapter_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned INC_WIDTH  = 8
) ();
    logic [DATA_WIDTH-1:0]   sn_TDATA;
    logic [DATA_WIDTH/8-1:0] sn_TKEEP;
    logic                    sn_TLAST;
    logic                    sn_TVALID;
    logic                    sn_TREADY;
    logic                    buf_rdy;
    logic                    pm_clr;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   idata;
    logic [INC_WIDTH-1:0]    byte_inc;
    logic                    done;
    logic                    trunc;
    logic                    done_ack;

    modport slave (
        input  sn_TDATA, sn_TKEEP, sn_TLAST, sn_TVALID, buf_rdy, done_ack,
        output sn_TREADY, pm_clr, wr_en, addr, idata, byte_inc, done, trunc
    );

    modport master (
        output sn_TDATA, sn_TKEEP, sn_TLAST, sn_TVALID, buf_rdy, done_ack,
        input  sn_TREADY, pm_clr, wr_en, addr, idata, byte_inc, done, trunc
    );
endinterface

// File: rtl/p_ng_wr_adapter.sv
// Stream-to-packet-memory write adapter: one registered write per accepted beat, truncation on overflow.
// Optional per-packet statistics counters under `P_NG_WR_STATS_EN.
module p_ng_wr_adapter #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned INC_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst_n,
    p_ng_wr_adapter_if.slave bus
`ifdef P_NG_WR_STATS_EN
    ,
    output logic [31:0] pkt_cnt,
    output logic [31:0] trunc_cnt
`endif
);
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, CLEAR, WRITE, DONE} state_t;

    state_t                state, state_nxt;
    logic                  tready, clr;
    logic                  hs, enter_done;
    logic                  done_q;
    logic                  full;
    logic [ADDR_WIDTH-1:0] ptr;

    function automatic logic [INC_WIDTH-1:0] popcount(input logic [KEEP_W-1:0] k);
        logic [INC_WIDTH-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) c = c + INC_WIDTH'(k[i]);
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // DONE only leaves once done has actually been presented, so the ack always pairs with a visible done.
    always_comb begin
        state_nxt = state;
        tready    = 1'b0;
        clr       = 1'b0;
        unique case (state)
            IDLE:  if (bus.buf_rdy) state_nxt = CLEAR;
            CLEAR: begin
                clr       = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                tready = 1'b1;
                if (bus.sn_TVALID && bus.sn_TLAST) state_nxt = DONE;
            end
            DONE:  if (bus.done_ack && done_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign hs            = bus.sn_TVALID && tready;
    assign enter_done    = hs && bus.sn_TLAST;
    assign bus.sn_TREADY = tready;
    assign bus.pm_clr    = clr;
    assign bus.done      = done_q;

    // done lags DONE entry by one cycle so the final write is committed before handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= (state == DONE) && !(done_q && bus.done_ack);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_en    <= 1'b0;
            bus.addr     <= '0;
            bus.idata    <= '0;
            bus.byte_inc <= '0;
            bus.trunc    <= 1'b0;
            ptr          <= '0;
            full         <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            if (clr) begin
                ptr       <= '0;
                full      <= 1'b0;
                bus.trunc <= 1'b0;
            end else if (hs) begin
                if (!full && (bus.sn_TKEEP != '0)) begin
                    bus.wr_en    <= 1'b1;
                    bus.addr     <= ptr;
                    bus.idata    <= bus.sn_TDATA;
                    bus.byte_inc <= popcount(bus.sn_TKEEP);
                    ptr          <= ptr + ADDR_WIDTH'(1);
                    if ((ptr == '1) && !bus.sn_TLAST) full <= 1'b1;
                end
                if (bus.sn_TLAST) bus.trunc <= full;
            end
        end
    end

`ifdef P_NG_WR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt   <= '0;
            trunc_cnt <= '0;
        end else if (enter_done) begin
            if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 32'd1;
            if (full && (trunc_cnt != '1)) trunc_cnt <= trunc_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_p_ng_wr_adapter.sv
// Self-checking bench for p_ng_wr_adapter (4-word buffer) with a packet-level reference model.
module tb_p_ng_wr_adapter;
    localparam int AW = 2;
    localparam int DW = 64;
    localparam int IW = 8;
    localparam int KW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    p_ng_wr_adapter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INC_WIDTH(IW)) bus ();

`ifdef P_NG_WR_STATS_EN
    logic [31:0] pkt_cnt, trunc_cnt;
`endif

    p_ng_wr_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INC_WIDTH(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef P_NG_WR_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt),
        .trunc_cnt (trunc_cnt)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [AW-1:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];
    logic [IW-1:0] wq_inc[$];
    int   cyc = 0, last_wr_cyc = 0, done_rise_cyc = 0, clr_cnt = 0;
    logic done_prev = 1'b0;

    int            pk_n;
    logic [KW-1:0] pk_keep[16];
    logic [DW-1:0] pk_data[16];
    int            exp_pkt = 0, exp_trc = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.wr_en === 1'b1) begin
            wq_addr.push_back(bus.addr);
            wq_data.push_back(bus.idata);
            wq_inc.push_back(bus.byte_inc);
            last_wr_cyc = cyc;
        end
        if (bus.pm_clr === 1'b1) clr_cnt++;
        if (bus.done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
        done_prev = bus.done;
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [KW-1:0] keep_of(input int k);
        logic [KW-1:0] m;
        m = '1;
        if (k == 0) return '0;
        return m << (KW - k);
    endfunction

    task automatic drive_beat(input int i, input int gaps, output bit ok);
        int t;
        ok = 1'b0;
        if (gaps == 2 || (gaps == 1 && $urandom_range(0, 2) == 0)) begin
            bus.sn_TVALID = 1'b0;
            repeat ((gaps == 2) ? 1 : $urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        bus.sn_TVALID = 1'b1;
        bus.sn_TDATA  = pk_data[i];
        bus.sn_TKEEP  = pk_keep[i];
        bus.sn_TLAST  = (i == pk_n - 1);
        t = 0;
        sample();
        while (bus.sn_TREADY !== 1'b1 && t < 100) begin
            sample();
            t++;
        end
        if (bus.sn_TREADY !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL tready_timeout beat %0d: tready=%b required 1", i, bus.sn_TREADY);
            bus.sn_TVALID = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.sn_TVALID = 1'b0;
        ok = 1'b1;
    endtask

    task automatic run_packet(input string nm, input int gaps);
        int base, clr0, t, ec, four;
        bit ok, exp_trunc;
        logic [DW-1:0] e_data[4];
        logic [IW-1:0] e_inc[4];
        base = wq_addr.size();
        clr0 = clr_cnt;
        for (int i = 0; i < pk_n; i++) begin
            drive_beat(i, gaps, ok);
            if (!ok) return;
        end
        t = 0;
        while (bus.done !== 1'b1 && t < 20) begin
            sample();
            t++;
        end
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: done=%b required 1", nm, bus.done);
            return;
        end

        // Packet-level model: first four non-empty beats land at words 0..3, anything after the 4th write truncates.
        ec = 0;
        four = -1;
        for (int i = 0; i < pk_n; i++) begin
            if (ec < 4 && pk_keep[i] != '0) begin
                e_data[ec] = pk_data[i];
                e_inc[ec]  = IW'($countones(pk_keep[i]));
                if (ec == 3) four = i;
                ec++;
            end
        end
        exp_trunc = (four >= 0) && (four < pk_n - 1);
        exp_pkt++;
        if (exp_trunc) exp_trc++;

        n_cmp++;
        if (wq_addr.size() - base != ec) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d required %0d", nm, wq_addr.size() - base, ec);
        end
        for (int j = 0; j < ec && base + j < wq_addr.size(); j++) begin
            n_cmp++;
            if (wq_addr[base+j] !== AW'(j) || wq_data[base+j] !== e_data[j] || wq_inc[base+j] !== e_inc[j]) begin
                n_fail++;
                $display("FAIL %s write%0d: addr=%0d data=%h inc=%0d required addr=%0d data=%h inc=%0d",
                         nm, j, wq_addr[base+j], wq_data[base+j], wq_inc[base+j], j, e_data[j], e_inc[j]);
            end
        end
        n_cmp++;
        if (bus.trunc !== exp_trunc) begin
            n_fail++;
            $display("FAIL %s trunc: got %b required %b", nm, bus.trunc, exp_trunc);
        end
        n_cmp++;
        if (clr_cnt - clr0 != 1) begin
            n_fail++;
            $display("FAIL %s pm_clr_pulses: got %0d required 1", nm, clr_cnt - clr0);
        end
        if (!exp_trunc && pk_keep[pk_n-1] != '0) begin
            n_cmp++;
            if (done_rise_cyc != last_wr_cyc + 1) begin
                n_fail++;
                $display("FAIL %s done_latency: done at cycle %0d required %0d", nm, done_rise_cyc, last_wr_cyc + 1);
            end
        end
`ifdef P_NG_WR_STATS_EN
        n_cmp++;
        if (pkt_cnt !== 32'(exp_pkt) || trunc_cnt !== 32'(exp_trc)) begin
            n_fail++;
            $display("FAIL %s stats: pkt=%0d trunc=%0d required pkt=%0d trunc=%0d",
                     nm, pkt_cnt, trunc_cnt, exp_pkt, exp_trc);
        end
`endif
        bus.done_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.done_ack = 1'b0;
        sample();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.sn_TREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_ack: done=%b tready=%b required 0 0", nm, bus.done, bus.sn_TREADY);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.buf_rdy   = 1'b0;
        bus.sn_TVALID = 1'b1;
        bus.sn_TKEEP  = '1;
        bus.sn_TDATA  = '1;
        bus.sn_TLAST  = 1'b0;
        bus.done_ack  = 1'b0;
        repeat (3) @(posedge clk);
        sample();
        n_cmp++;
        if ({bus.sn_TREADY, bus.pm_clr, bus.wr_en, bus.done, bus.trunc} !== 5'b0 ||
            bus.addr !== '0 || bus.idata !== '0 || bus.byte_inc !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: tready=%b clr=%b wr=%b done=%b trunc=%b addr=%0d idata=%h inc=%0d required all 0",
                     bus.sn_TREADY, bus.pm_clr, bus.wr_en, bus.done, bus.trunc, bus.addr, bus.idata, bus.byte_inc);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample();
            n_cmp++;
            if ({bus.sn_TREADY, bus.pm_clr, bus.wr_en, bus.done} !== 4'b0) begin
                n_fail++;
                $display("FAIL idle_no_buf cycle %0d: tready=%b clr=%b wr=%b done=%b required 0",
                         i, bus.sn_TREADY, bus.pm_clr, bus.wr_en, bus.done);
            end
        end
`ifdef P_NG_WR_STATS_EN
        n_cmp++;
        if (pkt_cnt !== 32'd0 || trunc_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stats: pkt=%0d trunc=%0d required 0 0", pkt_cnt, trunc_cnt);
        end
`endif
        bus.sn_TVALID = 1'b0;
        bus.buf_rdy   = 1'b1;
    endtask

    task automatic test_basic();
        pk_n = 3;
        pk_keep[0] = 8'hFF; pk_keep[1] = 8'hFF; pk_keep[2] = 8'hF0;
        for (int i = 0; i < 3; i++) pk_data[i] = {$urandom(), $urandom()};
        run_packet("basic", 0);
    endtask

    task automatic test_backpressure();
        pk_n = 2;
        pk_keep[0] = 8'hFF; pk_keep[1] = 8'hFC;
        for (int i = 0; i < 2; i++) pk_data[i] = {$urandom(), $urandom()};
        run_packet("backpressure", 2);
    endtask

    task automatic test_zero_keep();
        pk_n = 4;
        pk_keep[0] = 8'hFF; pk_keep[1] = 8'h00; pk_keep[2] = 8'hFF; pk_keep[3] = 8'hC0;
        for (int i = 0; i < 4; i++) pk_data[i] = {$urandom(), $urandom()};
        run_packet("zero_keep", 0);
    endtask

    task automatic test_exact_fit();
        pk_n = 4;
        for (int i = 0; i < 4; i++) begin
            pk_keep[i] = 8'hFF;
            pk_data[i] = {$urandom(), $urandom()};
        end
        run_packet("exact_fit", 0);
    endtask

    task automatic test_truncation();
        pk_n = 6;
        for (int i = 0; i < 6; i++) begin
            pk_keep[i] = 8'hFF;
            pk_data[i] = {$urandom(), $urandom()};
        end
        run_packet("truncation", 1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 30; p++) begin
            pk_n = $urandom_range(1, 7);
            for (int i = 0; i < pk_n; i++) begin
                pk_keep[i] = keep_of(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8));
                pk_data[i] = {$urandom(), $urandom()};
            end
            run_packet("random", 1);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        pk_n = 5;
        for (int i = 0; i < 5; i++) begin
            pk_keep[i] = 8'hFF;
            pk_data[i] = {$urandom(), $urandom()};
        end
        drive_beat(0, 0, ok);
        if (ok) drive_beat(1, 0, ok);
        sample();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.sn_TREADY, bus.pm_clr, bus.wr_en, bus.done, bus.trunc} !== 5'b0 ||
            bus.addr !== '0 || bus.idata !== '0 || bus.byte_inc !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: tready=%b wr=%b done=%b addr=%0d idata=%h inc=%0d required all 0",
                     bus.sn_TREADY, bus.wr_en, bus.done, bus.addr, bus.idata, bus.byte_inc);
        end
`ifdef P_NG_WR_STATS_EN
        n_cmp++;
        if (pkt_cnt !== 32'd0 || trunc_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset_stats: pkt=%0d trunc=%0d required 0 0", pkt_cnt, trunc_cnt);
        end
`endif
        exp_pkt = 0;
        exp_trc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pk_n = 3;
        for (int i = 0; i < 3; i++) begin
            pk_keep[i] = keep_of($urandom_range(1, 8));
            pk_data[i] = {$urandom(), $urandom()};
        end
        run_packet("after_reset", 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_keep();
        test_exact_fit();
        test_truncation();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
